// File: rtl/eth_unpacker.sv
// eth_unpacker: RMII receive path. Locks on preamble/SFD, filters on
// destination address, strips the header, forwards payload dibits with the
// trailing FCS held back, and reports a per-frame CRC verdict.
module eth_unpacker #(
    parameter logic [47:0] MY_ADDR        = 48'h69695A065491,
    parameter bit          ACCEPT_BCAST   = 1'b1,
    parameter int unsigned PRE_MIN_DIBITS = 8,
    parameter int unsigned MAX_DIBITS     = 6144,
    parameter logic [31:0] CRC_RESIDUE    = 32'hC704DD7B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phy_crsdv,
    input  logic [1:0] phy_rxd,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       kill,
    output logic       done,
    output logic       crc_ok
);

    localparam int unsigned PRE_W = $clog2(PRE_MIN_DIBITS + 1);
    localparam int unsigned CNT_W = $clog2(MAX_DIBITS + 1);
    localparam int unsigned DCNT_W = 5;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    localparam logic [2:0] S_RESYNC = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_PRE    = 3'd2;
    localparam logic [2:0] S_DEST   = 3'd3;
    localparam logic [2:0] S_SRC    = 3'd4;
    localparam logic [2:0] S_LEN    = 3'd5;
    localparam logic [2:0] S_DATA   = 3'd6;
    localparam logic [2:0] S_DROP   = 3'd7;

    // CRC32 update for one dibit; bit 0 is the first bit on the wire
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic [2:0]        r_state, w_state;
    logic [PRE_W-1:0]  r_pre, w_pre;
    logic [CNT_W-1:0]  r_cnt, w_cnt, w_cnt_inc;
    logic              r_match, w_match, r_bcast, w_bcast;
    logic [47:0]       r_addr, w_addr;
    logic [31:0]       r_crc, w_crc, w_crc_in;
    logic [31:0]       r_sr, w_sr;
    logic [DCNT_W-1:0] r_dcnt, w_dcnt;
    logic              w_axiov, w_kill, w_done, w_crc_ok;
    logic [1:0]        w_axiod;
    logic              w_dest_hit, w_dest_bc;

    // Next-state and next-output logic
    always_comb begin
        w_state    = r_state;
        w_pre      = r_pre;
        w_cnt      = r_cnt;
        w_match    = r_match;
        w_bcast    = r_bcast;
        w_addr     = r_addr;
        w_crc      = r_crc;
        w_sr       = r_sr;
        w_dcnt     = r_dcnt;
        w_axiov    = 1'b0;
        w_axiod    = 2'b00;
        w_kill     = 1'b0;
        w_done     = 1'b0;
        w_crc_ok   = 1'b0;
        w_crc_in   = crc_dibit(r_crc, phy_rxd);
        w_cnt_inc  = r_cnt + CNT_W'(1);
        w_dest_hit = r_match && (phy_rxd == r_addr[47:46]);
        w_dest_bc  = r_bcast && (phy_rxd == 2'b11);

        case (r_state)
            S_RESYNC: begin
                if (!phy_crsdv) w_state = S_IDLE;
            end
            S_IDLE: begin
                if (phy_crsdv) begin
                    if (phy_rxd == 2'b01) begin
                        w_state = S_PRE;
                        w_pre   = PRE_W'(1);
                    end else begin
                        w_state = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!phy_crsdv) begin
                    w_state = S_IDLE;
                end else if (phy_rxd == 2'b01) begin
                    if (r_pre != '1) w_pre = r_pre + PRE_W'(1);
                end else if (phy_rxd == 2'b11 && r_pre >= PRE_W'(PRE_MIN_DIBITS)) begin
                    w_state = S_DEST;
                    w_crc   = '1;
                    w_cnt   = '0;
                    w_match = 1'b1;
                    w_bcast = 1'b1;
                    w_addr  = MY_ADDR;
                    w_sr    = '0;
                    w_dcnt  = '0;
                end else begin
                    w_state = S_DROP;
                end
            end
            S_DEST, S_SRC, S_LEN, S_DATA: begin
                if (!phy_crsdv) begin
                    // carrier loss ends the frame; only a Data-phase end is reported
                    w_state = S_IDLE;
                    w_sr    = '0;
                    w_dcnt  = '0;
                    if (r_state == S_DATA) begin
                        w_done   = 1'b1;
                        w_crc_ok = (r_crc == CRC_RESIDUE);
                    end
                end else begin
                    w_crc = w_crc_in;
                    w_cnt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(MAX_DIBITS)) begin
                        w_kill  = 1'b1;
                        w_state = S_DROP;
                    end else begin
                        case (r_state)
                            S_DEST: begin
                                w_match = w_dest_hit;
                                w_bcast = w_dest_bc;
                                w_addr  = {r_addr[45:0], 2'b00};
                                if (r_cnt == CNT_W'(23)) begin
                                    if (!(w_dest_hit || (ACCEPT_BCAST && w_dest_bc))) begin
                                        w_kill  = 1'b1;
                                        w_state = S_DROP;
                                    end else begin
                                        w_state = S_SRC;
                                    end
                                end
                            end
                            S_SRC: begin
                                if (r_cnt == CNT_W'(47)) w_state = S_LEN;
                            end
                            S_LEN: begin
                                if (r_cnt == CNT_W'(55)) w_state = S_DATA;
                            end
                            default: begin
                                // 16-dibit delay line keeps the FCS from being forwarded
                                w_sr = {r_sr[29:0], phy_rxd};
                                if (r_dcnt == DCNT_W'(16)) begin
                                    w_axiov = 1'b1;
                                    w_axiod = r_sr[31:30];
                                end else begin
                                    w_dcnt = r_dcnt + DCNT_W'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            S_DROP: begin
                if (!phy_crsdv) w_state = S_IDLE;
            end
            default: begin
                w_state = S_RESYNC;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RESYNC;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_match <= 1'b0;
            r_bcast <= 1'b0;
            r_addr  <= '0;
            r_crc   <= '0;
            r_sr    <= '0;
            r_dcnt  <= '0;
            axiov   <= 1'b0;
            axiod   <= 2'b00;
            kill    <= 1'b0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_cnt   <= w_cnt;
            r_match <= w_match;
            r_bcast <= w_bcast;
            r_addr  <= w_addr;
            r_crc   <= w_crc;
            r_sr    <= w_sr;
            r_dcnt  <= w_dcnt;
            axiov   <= w_axiov;
            axiod   <= w_axiod;
            kill    <= w_kill;
            done    <= w_done;
            crc_ok  <= w_crc_ok;
        end
    end

endmodule

// File: doc/eth_unpacker.md
Name: eth_unpacker

Overview:
RMII-side Ethernet frame receiver, the receive-path counterpart of the team's eth_packer transmitter. It consumes dibits from the PHY, locks on preamble/SFD, and filters on destination address. It strips destination, source and length, then streams payload dibits downstream with the 32-bit FCS removed. It checks the FCS and reports a per-frame done/crc_ok verdict.

Parameters:
MY_ADDR, 48'h69695A065491, station address in wire order; address dibit k is compared to MY_ADDR[47-2k -: 2].
ACCEPT_BCAST, 1, when 1, an all-2'b11 destination is also accepted.
PRE_MIN_DIBITS, 8, minimum number of consecutive 2'b01 dibits required before the SFD dibit.
MAX_DIBITS, 6144, maximum number of dibits accepted after the SFD before the frame is aborted.
CRC_RESIDUE, 32'hC704DD7B, CRC32 register value after a correct frame including its FCS.

Ports:
clk  in  1  system clock; one dibit per cycle
rst  in  1  synchronous, active-high reset
phy_crsdv  in  1  carrier-sense/data-valid from the PHY; treated as a plain per-cycle valid
phy_rxd  in  2  received dibit
axiov  out  1  payload dibit valid
axiod  out  2  payload dibit
kill  out  1  one-cycle pulse: frame rejected (address mismatch or overflow)
done  out  1  one-cycle pulse: accepted frame ended
crc_ok  out  1  FCS verdict; meaningful only while done=1, 0 otherwise

Behaviour:
- Reset (rst=1 at a clk edge): state=Resync; axiov, axiod, kill, done, crc_ok all 0 from the next cycle; counters, shift register and CRC cleared.
- Resync: wait for phy_crsdv=0 for at least one cycle, then go to Idle. This prevents locking mid-frame after reset.
- Idle: on crsdv=1 with rxd=01, go to Preamble with the preamble count set to 1. On crsdv=1 with any other dibit, go to Drop.
- Preamble:
  - rxd=01: increment the count, saturating.
  - rxd=11 with count >= PRE_MIN_DIBITS: SFD; go to DestAddr and clear the CRC.
  - rxd=11 with count < PRE_MIN_DIBITS, or any other dibit: go to Drop.
  - crsdv=0: go to Idle.
- DestAddr (24 dibits): clear a per-frame match flag for any dibit that mismatches MY_ADDR; track the all-11 broadcast flag separately.
  - After the 24th dibit, if neither flag survives (broadcast counting only when ACCEPT_BCAST=1): pulse kill and go to Drop.
  - Otherwise go to SourceAddr.
- SourceAddr (24 dibits) then Length (8 dibits): contents ignored; dibits enter the CRC only.
- Data:
  - Every dibit from DestAddr onward feeds the CRC32 (same crc32 dibit convention as the transmit path) and a 16-dibit shift register.
  - A dibit is presented on axiod with axiov=1 once 16 newer dibits have arrived. axiov rises the cycle after the 17th Data dibit is received, so the final 16 dibits (FCS) are never forwarded.
  - Frames with fewer than 17 Data dibits forward nothing.
- End of frame: crsdv=0 in Data.
  - The following cycle: done=1 and crc_ok=(crc register == CRC_RESIDUE) for exactly one cycle.
  - The shift register is discarded and the block returns to Idle.
  - crsdv=0 during DestAddr, SourceAddr or Length: return to Idle with no done and no kill.
- Overflow: the dibit counter from SFD reaching MAX_DIBITS pulses kill and goes to Drop; no done.
- Drop: all outputs 0 except the kill pulse; remain in Drop until crsdv=0, then go to Idle.
- Simultaneous events: rst has priority over everything. A done pulse and a new frame's first preamble dibit in the same cycle are legal: the new dibit is processed from Idle.
- axiov is never asserted outside Data. No stall or backpressure exists; the downstream consumer must accept one dibit per cycle.

Test Plan:
1. Good broadcast frame: 31x01, then 11, then 24x11 dest, 24 source dibits, 8 length dibits, 20 data dibits 0,1,2,3 repeating, 16 correct FCS dibits, then crsdv=0 -> exactly 20 axiov cycles carrying 0,1,2,3..., then done=1 and crc_ok=1 for one cycle; kill stays 0.
2. Same frame with data dibit 7 flipped -> 20 axiov cycles (dibit 7 changed), then done=1 and crc_ok=0.
3. Unicast frame whose dest dibit 5 differs from MY_ADDR, with ACCEPT_BCAST=1 -> kill pulse one cycle after dest dibit 24; no axiov, no done; a good frame after 48 idle cycles is then received correctly.
4. Preamble with 00 at position 10; also SFD after only 4x01 -> Drop, no outputs; the frame is ignored until crsdv falls.
5. rst pulsed mid-Data with crsdv held high through the rest of the frame -> all outputs 0 from the next cycle, nothing received from that frame; the next full frame yields done=1 and crc_ok=1.
6. Two good frames separated by 48 idle cycles -> two independent done=1 and crc_ok=1 pulses with correct payload ordering for each.
